// File: rtl/line_refill_engine_pkg.sv
// Shared cache definitions for the line refill engine: FSM encoding,
// memory word geometry and the refill address concatenation width.
package line_refill_engine_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_RD   = 3'd1,
        WB_REQ  = 3'd2,
        WB_WAIT = 3'd3,
        RF_REQ  = 3'd4,
        RF_WAIT = 3'd5,
        RF_WR   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int WORD_WIDTH     = 32;
    localparam int BYTE_EN_WIDTH  = 4;
    localparam int WORD_ADDR_LSBS = 2;
    localparam logic [BYTE_EN_WIDTH-1:0] BYTE_EN_FULL = 4'hF;

    // Width of {tag, index, offset, 2'b00} before fitting onto the memory bus.
    function automatic int addr_cat_width(input int tag_w, input int index_w,
                                          input int offset_w);
        return tag_w + index_w + offset_w + WORD_ADDR_LSBS;
    endfunction

endpackage

// File: rtl/line_refill_engine_if.sv
// Miss-request, line-storage and memory-word ports of the refill engine.
// master = engine side, slave = cache/memory side.
interface line_refill_engine_if
    import line_refill_engine_pkg::*;
#(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic [INDEX_WIDTH-1:0]   req_index;
    logic                     victim_dirty;
    logic [TAG_WIDTH-1:0]     victim_tag;
    logic                     done;

    logic                     line_write_en;
    logic                     line_valid_in;
    logic                     line_dirty_in;
    logic [TAG_WIDTH-1:0]     line_tag_in;
    logic [OFFSET_WIDTH-1:0]  line_offset;
    logic [BYTE_EN_WIDTH-1:0] line_byte_en;
    logic [WORD_WIDTH-1:0]    line_data_in;
    logic [WORD_WIDTH-1:0]    line_data_out;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [WORD_WIDTH-1:0]     mem_req_wdata;
    logic                      mem_resp_valid;
    logic [WORD_WIDTH-1:0]     mem_resp_rdata;

    modport master (
        input  req_valid, req_tag, req_index, victim_dirty, victim_tag,
        output req_ready, done,
        output line_write_en, line_valid_in, line_dirty_in, line_tag_in,
        output line_offset, line_byte_en, line_data_in,
        input  line_data_out,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        output req_valid, req_tag, req_index, victim_dirty, victim_tag,
        input  req_ready, done,
        input  line_write_en, line_valid_in, line_dirty_in, line_tag_in,
        input  line_offset, line_byte_en, line_data_in,
        output line_data_out,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/line_refill_engine.sv
// Cache miss refill engine: optional word-by-word writeback of a dirty victim,
// then word-by-word refill of the missing line with one memory request in flight.
module line_refill_engine
    import line_refill_engine_pkg::*;
#(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    line_refill_engine_if.master bus
);

    localparam int ADDR_CAT_W = addr_cat_width(TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
    localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [OFFSET_WIDTH-1:0] CNT_ONE  = OFFSET_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic                    wcap_q, wcap_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [TAG_WIDTH-1:0]    vtag_q, vtag_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;

    logic [ADDR_CAT_W-1:0]   wb_addr, rf_addr;
    logic                    cnt_is_last;

    assign wb_addr     = {vtag_q, index_q, cnt_q, {WORD_ADDR_LSBS{1'b0}}};
    assign rf_addr     = {tag_q, index_q, cnt_q, {WORD_ADDR_LSBS{1'b0}}};
    assign cnt_is_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcap_q  <= wcap_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        vtag_q  <= vtag_d;
        index_q <= index_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcap_d  = wcap_q;
        tag_d   = tag_q;
        vtag_d  = vtag_q;
        index_d = index_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        bus.req_ready     = 1'b0;
        bus.done          = 1'b0;
        bus.line_write_en = 1'b0;
        bus.line_valid_in = 1'b0;
        bus.line_dirty_in = 1'b0;
        bus.line_tag_in   = '0;
        bus.line_offset   = '0;
        bus.line_byte_en  = '0;
        bus.line_data_in  = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    tag_d   = bus.req_tag;
                    index_d = bus.req_index;
                    vtag_d  = bus.victim_tag;
                    cnt_d   = '0;
                    state_d = bus.victim_dirty ? WB_RD : RF_REQ;
                end
            end
            WB_RD: begin
                bus.line_offset = cnt_q;
                wcap_d  = 1'b1;
                state_d = WB_REQ;
            end
            WB_REQ: begin
                // Line read data arrives in the first WB_REQ cycle; forward it
                // then and hold the captured copy while the request is stalled.
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = MEM_ADDR_WIDTH'(wb_addr);
                bus.mem_req_wdata = wcap_q ? bus.line_data_out : wdata_q;
                if (wcap_q) begin
                    wdata_d = bus.line_data_out;
                    wcap_d  = 1'b0;
                end
                if (bus.mem_req_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (bus.mem_resp_valid) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = cnt_is_last ? RF_REQ : WB_RD;
                end
            end
            RF_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = MEM_ADDR_WIDTH'(rf_addr);
                if (bus.mem_req_ready) state_d = RF_WAIT;
            end
            RF_WAIT: begin
                if (bus.mem_resp_valid) begin
                    rdata_d = bus.mem_resp_rdata;
                    state_d = RF_WR;
                end
            end
            RF_WR: begin
                // Valid goes in with the last word so a partial line never looks valid.
                bus.line_write_en = 1'b1;
                bus.line_offset   = cnt_q;
                bus.line_byte_en  = BYTE_EN_FULL;
                bus.line_tag_in   = tag_q;
                bus.line_valid_in = cnt_is_last;
                bus.line_data_in  = rdata_q;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = cnt_is_last ? DONE : RF_REQ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/line_refill_engine.md
LINE_REFILL_ENGINE -- requirements
Module: line_refill_engine

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 20, tag bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, set-index bits.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 4, word-offset bits; line = 2**OFFSET_WIDTH 32-bit words.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  miss request.
REQ-007 req_ready  output  1  engine idle; a request is accepted when req_valid && req_ready.
REQ-008 req_tag  input  TAG_WIDTH  tag of missing line.
REQ-009 req_index  input  INDEX_WIDTH  set index of missing line.
REQ-010 victim_dirty  input  1  victim line needs writeback.
REQ-011 victim_tag  input  TAG_WIDTH  victim tag, for writeback address.
REQ-012 done  output  1  one-cycle pulse: refill complete.
REQ-013 line_write_en  output  1  line storage write strobe.
REQ-014 line_valid_in  output  1  valid bit written with strobe.
REQ-015 line_dirty_in  output  1  dirty bit written with strobe.
REQ-016 line_tag_in  output  TAG_WIDTH  tag written with strobe.
REQ-017 line_offset  output  OFFSET_WIDTH  word offset for line read/write.
REQ-018 line_byte_en  output  4  byte enables for line write.
REQ-019 line_data_in  output  32  word written to line.
REQ-020 line_data_out  input  32  line read data, registered: valid the cycle after line_offset is presented.
REQ-021 mem_req_valid  output  1  memory word request.
REQ-022 mem_req_ready  input  1  memory accepts request.
REQ-023 mem_req_we  output  1  1 write, 0 read.
REQ-024 mem_req_addr  output  32  byte address {tag, index, offset, 2'b00}.
REQ-025 mem_req_wdata  output  32  write data.
REQ-026 mem_resp_valid  input  1  one response per accepted request (write ack or read data).
REQ-027 mem_resp_rdata  input  32  read data, valid with mem_resp_valid.

Function
REQ-028 SHALL implement states IDLE, WB_RD, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RF_WR, DONE; req_ready = 1 only in IDLE.
REQ-029 SHALL latch req_tag/req_index/victim_tag/victim_dirty on acceptance, clear word counter cnt to 0, and go to WB_RD if victim_dirty else RF_REQ; inputs ignored until return to IDLE.
REQ-030 WB_RD: line_offset = cnt for one cycle, then WB_REQ; SHALL capture line_data_out on entry to WB_REQ and hold it as mem_req_wdata.
REQ-031 WB_REQ: mem_req_valid = 1, we = 1, addr {victim_tag, index, cnt, 2'b00}; SHALL hold all request fields stable until mem_req_ready, then WB_WAIT.
REQ-032 WB_WAIT: on mem_resp_valid, cnt+1 and WB_RD; if cnt was all-ones, cnt wraps to 0 and go to RF_REQ.
REQ-033 RF_REQ: mem_req_valid = 1, we = 0, addr {req_tag, index, cnt, 2'b00}; held until accepted, then RF_WAIT.
REQ-034 RF_WAIT: on mem_resp_valid, register rdata and go to RF_WR.
REQ-035 RF_WR: one-cycle line_write_en = 1, line_offset = cnt, byte_en = 4'hF, tag_in = req_tag, dirty_in = 0, valid_in = 1 only when cnt all-ones else 0; then cnt+1 and RF_REQ, or DONE after the last word.
REQ-036 DONE: done = 1 for exactly one cycle, then IDLE; no line or memory strobe.
REQ-037 SHALL keep at most one memory request outstanding; mem_resp_valid outside WB_WAIT/RF_WAIT ignored; line_write_en never asserted outside RF_WR.
REQ-038 Latency, clean victim, zero-wait memory (ready and resp each 1 cycle after request): 3*2**OFFSET_WIDTH+1 cycles acceptance-to-done; dirty adds 3*2**OFFSET_WIDTH.

Reset
REQ-039 With rst = 0 at a posedge: state IDLE, cnt 0, all strobes/outputs 0 except req_ready = 1; mid-operation reset SHALL abort at once, leaving the line invalid or partially written.

Structure
REQ-040 State encoding and the address-concatenation width constant SHALL live in the shared cache package with the other cache definitions.
REQ-041 Single module; no sub-module.

Verification
REQ-042 Clean miss, tag 0x12345, index 5, memory returns offset*0x11: 16 reads addr 0x12345140..0x1234517C, 16 line writes, valid_in = 1 only at offset 15, done once.
REQ-043 Dirty victim tag 0xABCDE, index 5: 16 writes to 0xABCDE140.. with wdata = line contents, in offset order, before first read.
REQ-044 mem_req_ready low 3 cycles in WB_REQ: addr/wdata/we held stable, exactly 16 writes issued.
REQ-045 req_valid held high after done: next request accepted the cycle after done; spurious mem_resp_valid in IDLE: no effect.
REQ-046 rst low at refill word 7: next cycle IDLE, req_ready = 1, no strobes; new request completes normally.
